mak8_run_ctrl: RTL and testbench
================================

Name: mak8_run_ctrl

Overview:
Parametrised CPU run controller for the MAK-8 board top level. It replaces the divided or gated CPU clock with a single-cycle clock-enable (`cpu_ce`) in the `clk` domain. It adds four run modes: halt, free-run at a programmable rate, debounced single-step, and N-step burst. It also keeps a retired-step counter for display. The CPU core runs on `clk` and advances only when `cpu_ce` is high.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a step-button level change (10 ms at 100 MHz); must be ≥1.
RATE_W, 32, width of `rate_div`.
BURST_W, 8, width of `burst_len` and of the remaining-steps counter.
CNT_W, 16, width of `step_count`.

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
run_sw  in  1  asynchronous run-enable switch; 0 forces halt
step_btn  in  1  asynchronous, bouncy step/trigger button
mode  in  2  00 halt, 01 free-run, 10 single-step, 11 burst; quasi-static, sampled every cycle
rate_div  in  RATE_W  free-run/burst period in clk cycles; 0 and 1 both mean every cycle
burst_len  in  BURST_W  steps per burst; 0 means a trigger is ignored
cpu_halted  in  1  CPU HALT status, synchronous to clk
cpu_ce  out  1  one-cycle CPU clock-enable pulse, registered
state  out  2  current state encoding (below), registered
busy  out  1  burst in progress
step_count  out  CNT_W  number of `cpu_ce` pulses issued; wraps to 0 after all-ones

Behaviour:
- Reset (synchronous, `rst`=1):
  - `cpu_ce`=0, `busy`=0, `step_count`=0, `state`=HALT.
  - Synchroniser flops, debounced level, debounce counter, tick counter and remaining counter all cleared.
  - Reset asserted mid-burst aborts the burst with no further pulses.
- Input conditioning:
  - `run_sw` and `step_btn` each pass through a 2-flop synchroniser.
  - The debouncer counts consecutive cycles in which the synchronised button differs from the debounced level. It resets the count whenever they match. When the count reaches DEBOUNCE_CYCLES, the debounced level flips.
  - `step_req` is a one-cycle pulse on the debounced rising edge.
  - Clean raw rise to `step_req` latency = DEBOUNCE_CYCLES+2 cycles; `cpu_ce` follows one cycle later.
- State register (encoding: HALT 00, FREE 01, STEP 10, BURST 11), evaluated every cycle:
  - sync `run_sw`=0 or `mode`=00 → HALT.
  - Otherwise the state is `mode`.
  - Any change of state clears the tick counter, the remaining counter and `busy`. A running burst is thereby aborted.
- Effective divider: div_eff = max(`rate_div`, 1).
- HALT: `cpu_ce` stays 0.
- FREE:
  - Tick counter increments each cycle.
  - When it reaches div_eff−1, the counter wraps to 0 and `cpu_ce`=1 in the following cycle.
  - The first pulse comes div_eff cycles after the first cycle with `state`=FREE.
  - If `rate_div` shrinks below the current count, the next cycle treats the count as terminal: it fires and wraps.
- STEP: each `step_req` produces exactly one `cpu_ce` pulse, one cycle later. The tick counter is unused.
- BURST:
  - A `step_req` with `busy`=0 and `burst_len`≠0 loads remaining=`burst_len`, clears the tick counter and sets `busy`=1 next cycle.
  - While `busy`, pulses are paced as in FREE (first pulse div_eff cycles after `busy` rises). Remaining decrements on each pulse.
  - `busy` clears the cycle after the pulse that brings remaining to 0.
  - `step_req` while `busy` is ignored, not queued.
- `cpu_halted`=1:
  - Suppresses `cpu_ce` in all states.
  - Holds the FREE tick counter.
  - In BURST, aborts the burst (remaining=0, `busy`=0 next cycle).
  - In STEP, a `step_req` arriving while halted is dropped.
- `step_count` increments by 1 on every cycle with `cpu_ce`=1 and wraps modulo 2^CNT_W. It is cleared only by `rst`.
- `cpu_ce` is never high on two consecutive cycles unless div_eff=1 in FREE/BURST.

Test Plan:
1. `mode`=01, `run_sw`=1, `rate_div`=4, run 40 cycles → `cpu_ce` pulses every 4th cycle, first 4 cycles after `state`=FREE, `step_count`=9 or 10 consistent with pulse count; repeat with `rate_div`=0 and 1 → `cpu_ce` high every cycle.
2. DEBOUNCE_CYCLES=8, `mode`=10; `step_btn` toggles 5 times at 2-cycle spacing, then held high 20 cycles → exactly one `cpu_ce`, 11 cycles after the final stable rise; release bounce → no pulse.
3. `mode`=11, `burst_len`=3, `rate_div`=2, one clean press → 3 pulses spaced 2 cycles, `busy` high throughout, low one cycle after the 3rd; a second press mid-burst → still exactly 3 pulses.
4. Burst `burst_len`=10, assert `cpu_halted` after the 2nd pulse → no further `cpu_ce`, `busy`=0 next cycle, `step_count`=2; repeat with `run_sw`→0 mid-burst → `state`=HALT after sync latency, same abort.
5. Preload via 65535 FREE pulses at div_eff=1 → `step_count`=0xFFFF, next pulse → 0x0000.
6. Assert `rst` for 1 cycle during FREE with count mid-period → all outputs at reset values next cycle; after release, first pulse exactly div_eff cycles after re-entering FREE.

Source files
------------

// File: rtl/mak8_run_ctrl.sv
// MAK-8 CPU run controller: turns run switch, step button and mode into a single-cycle
// CPU clock-enable with halt, free-run, single-step and N-step burst modes.
module mak8_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RATE_W          = 32,
    parameter int unsigned BURST_W         = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic [1:0]         mode,
    input  logic [RATE_W-1:0]  rate_div,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               cpu_halted,
    output logic               cpu_ce,
    output logic [1:0]         state,
    output logic               busy,
    output logic [CNT_W-1:0]   step_count
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_FREE  = 2'b01,
        S_STEP  = 2'b10,
        S_BURST = 2'b11
    } state_e;

    logic               run_meta_q, run_sync_q;
    logic               btn_meta_q, btn_sync_q;
    logic               db_level_q, db_level_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               step_req_q, step_req_d;
    state_e             state_q, state_d;
    logic [RATE_W-1:0]  tick_q, tick_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               ce_q, ce_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RATE_W-1:0]  div_eff;
    logic               tick_terminal;

    // Debouncer: level flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        step_req_d = 1'b0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = btn_sync_q;
                step_req_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // A count at or beyond the period end is terminal, so a shrinking divider fires at once
    always_comb begin
        div_eff       = (rate_div == '0) ? RATE_W'(1) : rate_div;
        tick_terminal = (tick_q >= (div_eff - RATE_W'(1)));
    end

    // Run-mode FSM with tick pacing, burst bookkeeping and enable generation
    always_comb begin
        state_d = (run_sync_q && (mode != 2'b00)) ? state_e'(mode) : S_HALT;
        tick_d  = tick_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        ce_d    = 1'b0;
        count_d = count_q + CNT_W'(ce_q);

        if (state_d != state_q) begin
            tick_d = '0;
            rem_d  = '0;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    if (!cpu_halted) begin
                        if (tick_terminal) begin
                            tick_d = '0;
                            ce_d   = 1'b1;
                        end else begin
                            tick_d = tick_q + RATE_W'(1);
                        end
                    end
                end
                S_STEP: begin
                    ce_d = step_req_q && !cpu_halted;
                end
                S_BURST: begin
                    if (busy_q) begin
                        if (cpu_halted) begin
                            tick_d = '0;
                            rem_d  = '0;
                            busy_d = 1'b0;
                        end else if (rem_q == '0) begin
                            busy_d = 1'b0;
                        end else if (tick_terminal) begin
                            tick_d = '0;
                            rem_d  = rem_q - BURST_W'(1);
                            ce_d   = 1'b1;
                        end else begin
                            tick_d = tick_q + RATE_W'(1);
                        end
                    end else if (step_req_q && (burst_len != '0) && !cpu_halted) begin
                        tick_d = '0;
                        rem_d  = burst_len;
                        busy_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            step_req_q <= 1'b0;
            state_q    <= S_HALT;
            tick_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            ce_q       <= 1'b0;
            count_q    <= '0;
        end else begin
            run_meta_q <= run_sw;
            run_sync_q <= run_meta_q;
            btn_meta_q <= step_btn;
            btn_sync_q <= btn_meta_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            step_req_q <= step_req_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            ce_q       <= ce_d;
            count_q    <= count_d;
        end
    end

    assign cpu_ce     = ce_q;
    assign state      = state_q;
    assign busy       = busy_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_mak8_run_ctrl.sv
// Directed bench for mak8_run_ctrl with a short debounce window and hand-computed timing.
module tb_mak8_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic [1:0]  mode;
    logic [31:0] rate_div;
    logic [7:0]  burst_len;
    logic        cpu_halted;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        busy;
    logic [15:0] step_count;

    int checks   = 0;
    int failures = 0;

    mak8_run_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .RATE_W         (32),
        .BURST_W        (8),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .mode       (mode),
        .rate_div   (rate_div),
        .burst_len  (burst_len),
        .cpu_halted (cpu_halted),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .busy       (busy),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        run_sw     = 1'b0;
        step_btn   = 1'b0;
        mode       = 2'b00;
        rate_div   = 32'd0;
        burst_len  = 8'd0;
        cpu_halted = 1'b0;
        step_clk(2);
    endtask

    // Bounce: toggle the button n times at 2-cycle spacing
    task automatic bounce(input int n);
        for (int i = 0; i < n; i++) begin
            step_btn = ~step_btn;
            step_clk(2);
        end
    endtask

    int pulses;
    int first_k;

    initial begin
        do_reset();
        chk("rst_ce", 32'(cpu_ce), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        rst = 1'b0;

        // Free-run at rate 4: FREE after the 2-flop sync, first pulse 4 cycles later
        mode = 2'b01; rate_div = 32'd4; run_sw = 1'b1;
        step_clk(2);
        chk("t1_sync_halt", 32'(state), 32'd0);
        step_clk(1);
        chk("t1_state_free", 32'(state), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            step_clk(1);
            chk("t1_ce_div4", 32'(cpu_ce), 32'((k % 4) == 0));
        end
        chk("t1_count40", 32'(step_count), 32'd9);
        step_clk(1);
        chk("t1_count41", 32'(step_count), 32'd10);
        rate_div = 32'd0;
        for (int k = 0; k < 10; k++) begin
            step_clk(1);
            chk("t1_ce_div0", 32'(cpu_ce), 32'd1);
        end
        rate_div = 32'd1;
        for (int k = 0; k < 10; k++) begin
            step_clk(1);
            chk("t1_ce_div1", 32'(cpu_ce), 32'd1);
        end
        chk("t1_count61", 32'(step_count), 32'd29);
        mode = 2'b00;
        step_clk(1);
        chk("t1_halt_state", 32'(state), 32'd0);
        chk("t1_halt_ce", 32'(cpu_ce), 32'd0);
        chk("t1_halt_count", 32'(step_count), 32'd30);

        // Single step: bounces are rejected, one pulse 11 cycles after the final stable rise
        mode = 2'b10;
        step_clk(2);
        chk("t2_state_step", 32'(state), 32'd2);
        bounce(4);
        step_btn = 1'b1;
        pulses = 0; first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            step_clk(1);
            if (cpu_ce) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        chk("t2_latency", 32'(first_k), 32'd11);
        chk("t2_pulses", 32'(pulses), 32'd1);
        bounce(8);
        step_btn = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step_clk(1);
            if (cpu_ce) pulses++;
        end
        chk("t2_release_pulses", 32'(pulses), 32'd0);
        chk("t2_count", 32'(step_count), 32'd31);

        // Burst of 3 at rate 2: busy from k=11, pulses at 13/15/17, busy drops at 18
        mode = 2'b11; burst_len = 8'd3; rate_div = 32'd2;
        step_clk(1);
        chk("t3_state_burst", 32'(state), 32'd3);
        step_btn = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step_clk(1);
            chk("t3_ce", 32'(cpu_ce), 32'((k == 13) || (k == 15) || (k == 17)));
            chk("t3_busy", 32'(busy), 32'((k >= 11) && (k <= 17)));
            if (k == 12) step_btn = 1'b0;
        end
        chk("t3_count", 32'(step_count), 32'd34);

        // Burst of 3 at rate 8 with a second press whose step_req lands mid-burst (k=34)
        rate_div = 32'd8;
        step_btn = 1'b1;
        pulses = 0; first_k = 0;
        for (int k = 1; k <= 60; k++) begin
            step_clk(1);
            if (cpu_ce) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (k == 35) chk("t3b_busy35", 32'(busy), 32'd1);
            if (k == 36) chk("t3b_busy36", 32'(busy), 32'd0);
            if (k == 12) step_btn = 1'b0;
            if (k == 24) step_btn = 1'b1;
            if (k == 40) step_btn = 1'b0;
        end
        chk("t3b_first", 32'(first_k), 32'd19);
        chk("t3b_pulses", 32'(pulses), 32'd3);
        chk("t3b_busy_end", 32'(busy), 32'd0);
        chk("t3b_count", 32'(step_count), 32'd37);

        // Burst of 10 aborted by cpu_halted after the 2nd pulse
        burst_len = 8'd10; rate_div = 32'd2;
        step_btn = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            step_clk(1);
            if (cpu_ce) pulses++;
            if (k == 15) chk("t4_busy15", 32'(busy), 32'd1);
            if (k == 16) chk("t4_busy16", 32'(busy), 32'd0);
            if (k == 12) step_btn = 1'b0;
            if (k == 15) cpu_halted = 1'b1;
        end
        chk("t4_pulses", 32'(pulses), 32'd2);
        chk("t4_count", 32'(step_count), 32'd39);
        cpu_halted = 1'b0;

        // Same burst aborted by run_sw dropping after the 1st pulse; one in-flight pulse at 15
        step_btn = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            step_clk(1);
            if (cpu_ce) pulses++;
            if (k == 15) chk("t4b_state15", 32'(state), 32'd3);
            if (k == 16) chk("t4b_state16", 32'(state), 32'd0);
            if (k == 16) chk("t4b_busy16", 32'(busy), 32'd0);
            if (k == 12) step_btn = 1'b0;
            if (k == 13) run_sw = 1'b0;
        end
        chk("t4b_pulses", 32'(pulses), 32'd2);
        chk("t4b_count", 32'(step_count), 32'd41);

        // Counter wrap: 65535 pulses at every-cycle rate, then one more wraps to zero
        do_reset();
        rst = 1'b0;
        mode = 2'b01; rate_div = 32'd1; run_sw = 1'b1;
        for (int k = 0; k < 8 && state != 2'b01; k++) step_clk(1);
        chk("t5_enter", 32'(state), 32'd1);
        step_clk(65536);
        chk("t5_count_max", 32'(step_count), 32'h0000FFFF);
        step_clk(1);
        chk("t5_count_wrap", 32'(step_count), 32'd0);
        chk("t5_ce", 32'(cpu_ce), 32'd1);

        // Reset mid-period, then first pulse div_eff cycles after re-entering FREE
        rate_div = 32'd4;
        step_clk(2);
        rst = 1'b1;
        step_clk(1);
        chk("t6_ce", 32'(cpu_ce), 32'd0);
        chk("t6_state", 32'(state), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_count", 32'(step_count), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step_clk(1);
            if (k == 2) chk("t6_state2", 32'(state), 32'd0);
            if (k == 3) chk("t6_state3", 32'(state), 32'd1);
            chk("t6_ce_after", 32'(cpu_ce), 32'((k == 7) || (k == 11)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
